// File: rtl/and_check_pkg.sv
// Shared types and constants for the AND-gate exhaustive checker.
// Holds the sweep FSM state encoding, settle counter width and vector-count helper.
package and_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int numVec(input int nIn);
    return 1 << nIn;
  endfunction

endpackage

// File: rtl/and_gate_exhaustive_checker_if.sv
// Stimulus/response bundle between the checker (master) and the gate pair under test (slave).
interface and_gate_exhaustive_checker_if #(
  parameter int N_IN = 3
);

  logic              start;
  logic [N_IN-1:0]   vec_out;
  logic              out1;
  logic              out2;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic              first_fail_valid;
  logic [N_IN-1:0]   first_fail_vec;

  modport master (
    input  start, out1, out2,
    output vec_out, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );

  modport slave (
    output start, out1, out2,
    input  vec_out, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );

endinterface

// File: rtl/and_check_scoreboard.sv
// Golden AND compare, saturating failure count and first-failing-vector capture.
module and_check_scoreboard
  import and_check_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            sample_i,
  input  logic [N_IN-1:0] vec_i,
  input  logic            out1_i,
  input  logic            out2_i,
  output logic            fail_o,
  output logic [N_IN:0]   errCount_o,
  output logic            ffValid_o,
  output logic [N_IN-1:0] ffVec_o
);

  localparam logic [N_IN:0] ERR_MAX = (N_IN+1)'(numVec(N_IN));

  logic [N_IN:0]   errCount_q, errCount_d;
  logic            ffValid_q, ffValid_d;
  logic [N_IN-1:0] ffVec_q, ffVec_d;
  logic            golden;

  // Fail is the default so that an unknown response is never mistaken for a match.
  always_comb begin
    golden = &vec_i;
    fail_o = 1'b1;
    if ((out1_i == golden) && (out2_i == golden)) fail_o = 1'b0;
  end

  always_comb begin
    errCount_d = errCount_q;
    ffValid_d  = ffValid_q;
    ffVec_d    = ffVec_q;
    if (clear_i) begin
      errCount_d = '0;
      ffValid_d  = 1'b0;
      ffVec_d    = '0;
    end else if (sample_i && fail_o) begin
      if (errCount_q != ERR_MAX) errCount_d = errCount_q + 1'b1;
      if (!ffValid_q) begin
        ffValid_d = 1'b1;
        ffVec_d   = vec_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errCount_q <= '0;
      ffValid_q  <= 1'b0;
      ffVec_q    <= '0;
    end else begin
      errCount_q <= errCount_d;
      ffValid_q  <= ffValid_d;
      ffVec_q    <= ffVec_d;
    end
  end

  assign errCount_o = errCount_q;
  assign ffValid_o  = ffValid_q;
  assign ffVec_o    = ffVec_q;

endmodule

// File: rtl/and_gate_exhaustive_checker.sv
// Sweeps all 2^N_IN vectors into a flat/cascaded AND pair and scores both responses.
// Define HALT_ON_FAIL_EN to stop the sweep at the first failing vector.
module and_gate_exhaustive_checker
  import and_check_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  and_gate_exhaustive_checker_if.master bus
);

  localparam logic [N_IN-1:0]     LAST_VEC    = N_IN'(numVec(N_IN) - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
`ifdef HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [SETTLE_W-1:0] settleCnt_q, settleCnt_d;
  logic                clearSb;
  logic                sampleEn;
  logic                failNow;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settleCnt_d = settleCnt_q;
    clearSb     = 1'b0;
    sampleEn    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = SETTLE;
          vec_d       = '0;
          settleCnt_d = '0;
          clearSb     = 1'b1;
        end
      end
      SETTLE: begin
        if (settleCnt_q == SETTLE_LAST) begin
          state_d     = SAMPLE;
          settleCnt_d = '0;
        end else begin
          settleCnt_d = settleCnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        sampleEn = 1'b1;
        // Halting keeps vec_out on the failing vector so it can be probed.
        if ((HALT && failNow) || (vec_q == LAST_VEC)) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      settleCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settleCnt_q <= settleCnt_d;
    end
  end

  and_check_scoreboard #(.N_IN(N_IN)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clearSb),
    .sample_i   (sampleEn),
    .vec_i      (vec_q),
    .out1_i     (bus.out1),
    .out2_i     (bus.out2),
    .fail_o     (failNow),
    .errCount_o (bus.err_count),
    .ffValid_o  (bus.first_fail_valid),
    .ffVec_o    (bus.first_fail_vec)
  );

  assign bus.vec_out = vec_q;
  assign bus.busy    = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done    = (state_q == DONE);
  assign bus.pass    = (state_q == DONE) && (bus.err_count == '0);

endmodule

// File: tb/tb_and_gate_exhaustive_checker.sv
// Self-checking bench: two checker instances (N_IN=3/SETTLE_CYC=1 and N_IN=2/SETTLE_CYC=3)
// driven by a bench-side gate pair with injectable per-vector faults, scored against a sweep model.
module tb_and_gate_exhaustive_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  and_gate_exhaustive_checker_if #(.N_IN(3)) ifA ();
  and_gate_exhaustive_checker_if #(.N_IN(2)) ifB ();

  and_gate_exhaustive_checker #(.N_IN(3), .SETTLE_CYC(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  and_gate_exhaustive_checker #(.N_IN(2), .SETTLE_CYC(3)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] flip1A = '0, flip2A = '0;
  logic [3:0] flip1B = '0, flip2B = '0;
  logic       glitchB = 1'b0;

  // Gate pair under test: a correct AND with per-vector output inversions injected.
  always_comb begin
    ifA.out1 = (&ifA.vec_out) ^ flip1A[ifA.vec_out];
    ifA.out2 = (&ifA.vec_out) ^ flip2A[ifA.vec_out];
    ifB.out1 = (&ifB.vec_out) ^ flip1B[ifB.vec_out] ^ glitchB;
    ifB.out2 = (&ifB.vec_out) ^ flip2B[ifB.vec_out];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Sweep-level reference: which vectors fail, how many, and when done should rise.
  task automatic modelSweep(input int n, input int s, input logic [31:0] f1, input logic [31:0] f2,
                            output int errs, output int first, output bit found,
                            output int lat, output int lastV);
    int total;
    total = 1 << n;
    errs = 0; first = 0; found = 1'b0;
    for (int v = 0; v < total; v++) begin
      if (f1[v] || f2[v]) begin
        if (!found) begin found = 1'b1; first = v; end
        errs++;
      end
    end
    lat   = total * (s + 1);
    lastV = total - 1;
`ifdef HALT_ON_FAIL_EN
    if (found) begin
      errs  = 1;
      lat   = (first + 1) * (s + 1);
      lastV = first;
    end
`endif
  endtask

  task automatic applyStimulus(input logic [7:0] f1, input logic [7:0] f2,
                               input bit pulseStarts, input bit holdStart);
    int errs, first, lat, lastV, cyc;
    bit found;
    modelSweep(3, 1, {24'd0, f1}, {24'd0, f2}, errs, first, found, lat, lastV);
    flip1A = f1; flip2A = f2;
    ifA.start = 1'b1;
    @(posedge clk); #1;
    ifA.start = 1'b0;
    checkOutput("A accept busy", ifA.busy, 1);
    checkOutput("A accept done", ifA.done, 0);
    checkOutput("A accept vec", ifA.vec_out, 0);
    checkOutput("A accept err", ifA.err_count, 0);
    checkOutput("A accept ffvalid", ifA.first_fail_valid, 0);
    cyc = 0;
    while (!ifA.done && cyc < 200) begin
      if (pulseStarts) ifA.start = (cyc == 3 || cyc == 9);
      @(posedge clk); #1;
      cyc++;
      if (!ifA.done) begin
        checkOutput("A busy", ifA.busy, 1);
        checkOutput("A vec step", ifA.vec_out, cyc / 2);
      end
    end
    ifA.start = 1'b0;
    checkOutput("A latency", cyc, lat);
    checkOutput("A done", ifA.done, 1);
    checkOutput("A busy end", ifA.busy, 0);
    checkOutput("A pass", ifA.pass, (errs == 0));
    checkOutput("A err", ifA.err_count, errs);
    checkOutput("A ffvalid", ifA.first_fail_valid, found);
    checkOutput("A ffvec", ifA.first_fail_vec, found ? first : 0);
    checkOutput("A vec end", ifA.vec_out, lastV);
    if (holdStart) begin
      ifA.start = 1'b1;
      @(posedge clk); #1;
      checkOutput("A relaunch done", ifA.done, 0);
      checkOutput("A relaunch busy", ifA.busy, 1);
      checkOutput("A relaunch err", ifA.err_count, 0);
      checkOutput("A relaunch ffvalid", ifA.first_fail_valid, 0);
      ifA.start = 1'b0;
      cyc = 0;
      while (!ifA.done && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      checkOutput("A relaunch latency", cyc, lat);
      checkOutput("A relaunch err end", ifA.err_count, errs);
    end
  endtask

  task automatic runSweepB(input logic [3:0] f1, input logic [3:0] f2);
    int errs, first, lat, lastV, cyc;
    bit found;
    modelSweep(2, 3, {28'd0, f1}, {28'd0, f2}, errs, first, found, lat, lastV);
    flip1B = f1; flip2B = f2;
    ifB.start = 1'b1;
    @(posedge clk); #1;
    ifB.start = 1'b0;
    cyc = 0;
    while (!ifB.done && cyc < 200) begin
      glitchB = ((cyc % 4) != 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (!ifB.done) checkOutput("B vec step", ifB.vec_out, cyc / 4);
    end
    glitchB = 1'b0;
    checkOutput("B latency", cyc, lat);
    checkOutput("B done", ifB.done, 1);
    checkOutput("B pass", ifB.pass, (errs == 0));
    checkOutput("B err", ifB.err_count, errs);
    checkOutput("B ffvalid", ifB.first_fail_valid, found);
    checkOutput("B ffvec", ifB.first_fail_vec, found ? first : 0);
  endtask

  task automatic checkAllZeroA(input string tag);
    checkOutput({tag, " vec"}, ifA.vec_out, 0);
    checkOutput({tag, " busy"}, ifA.busy, 0);
    checkOutput({tag, " done"}, ifA.done, 0);
    checkOutput({tag, " pass"}, ifA.pass, 0);
    checkOutput({tag, " err"}, ifA.err_count, 0);
    checkOutput({tag, " ffvalid"}, ifA.first_fail_valid, 0);
    checkOutput({tag, " ffvec"}, ifA.first_fail_vec, 0);
  endtask

  initial begin
    logic [7:0] r1, r2;
    ifA.start = 1'b0;
    ifB.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZeroA("reset");
    checkOutput("reset B done", ifB.done, 0);
    checkOutput("reset B busy", ifB.busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle A done", ifA.done, 0);

    $display("[TB] good pair sweep");
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    $display("[TB] out2 fault at vector 5");
    applyStimulus(8'h00, 8'h20, 1'b0, 1'b0);
    $display("[TB] out1 stuck-at-0");
    applyStimulus(8'h80, 8'h00, 1'b0, 1'b0);
    $display("[TB] out2 stuck-at-1");
    applyStimulus(8'h00, 8'h7F, 1'b0, 1'b0);

    $display("[TB] reset mid-sweep");
    flip1A = 8'h00; flip2A = 8'h7F;
    ifA.start = 1'b1;
    @(posedge clk); #1;
    ifA.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkAllZeroA("midreset");
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);

    $display("[TB] start pulses while busy, then start held in DONE");
    applyStimulus(8'h00, 8'h12, 1'b1, 1'b1);

    $display("[TB] randomized fault masks");
    for (int i = 0; i < 6; i++) begin
      r1 = 8'($urandom) & 8'($urandom);
      r2 = 8'($urandom) & 8'($urandom) & 8'($urandom);
      applyStimulus(r1, r2, 1'b0, 1'b0);
    end

    $display("[TB] long settle instance with settle-time glitches");
    runSweepB(4'h0, 4'h0);
    runSweepB(4'($urandom), 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
